// File: rtl/dma_controller.sv
// Byte-wide DMA engine for a 6502-style bus: the CPU programs SRC/DST/LEN, and the engine stalls the CPU (RDY) while it copies.
// Optional fill mode (constant SRC_L written to DST) is built only when DMA_FILL_EN is defined.
module dma_controller #(
  parameter int BURST_LEN = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  output logic        rdy_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_dout_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_din_i,
  output logic        bus_own_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_READ, S_WRITE, S_RELEASE, S_FINISH
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [7:0]  burst_q, burst_d, burst_inc;
  logic        irq_en_q, irq_en_d, done_q, done_d;
  logic [7:0]  dout_q, rd_data;
  logic        reg_wr, busy, start;

`ifdef DMA_FILL_EN
  logic fill_q, fill_d;
`else
  logic fill_q;
  assign fill_q = 1'b0;
`endif

  assign reg_wr    = en_i & we_i;
  assign busy      = (state_q != S_IDLE);
  assign start     = reg_wr && (addr_i == 8'd6) && din_i[0] && !busy;
  assign burst_inc = burst_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    burst_d    = burst_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
`ifdef DMA_FILL_EN
    fill_d     = fill_q;
`endif
    rdy_o      = 1'b1;
    bus_own_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_addr_o = 16'h0000;
    bus_dout_o = 8'h00;

    // Address/length registers are frozen while a transfer owns them.
    if (reg_wr && !busy) begin
      case (addr_i)
        8'd0: src_d[7:0]  = din_i;
        8'd1: src_d[15:8] = din_i;
        8'd2: dst_d[7:0]  = din_i;
        8'd3: dst_d[15:8] = din_i;
        8'd4: len_d[7:0]  = din_i;
        8'd5: len_d[15:8] = din_i;
        default: ;
      endcase
    end
    if (reg_wr && addr_i == 8'd6) begin
      irq_en_d = din_i[1];
`ifdef DMA_FILL_EN
      if (!busy) fill_d = din_i[2];
`endif
    end
    if (reg_wr && addr_i == 8'd7) done_d = 1'b0;

    // FINISH is evaluated after the STATUS write so that setting done wins.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          burst_d = 8'd0;
          state_d = (len_q == 16'd0) ? S_FINISH : S_GRANT;
        end
      end
      S_GRANT: begin
        rdy_o   = 1'b0;
        state_d = fill_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        rdy_o      = 1'b0;
        bus_own_o  = 1'b1;
        bus_addr_o = src_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        rdy_o      = 1'b0;
        bus_own_o  = 1'b1;
        bus_we_o   = 1'b1;
        bus_addr_o = dst_q;
        bus_dout_o = fill_q ? src_q[7:0] : bus_din_i;
        src_d      = fill_q ? src_q : src_q + 16'd1;
        dst_d      = dst_q + 16'd1;
        len_d      = len_q - 16'd1;
        burst_d    = burst_inc;
        if (len_q == 16'd1)              state_d = S_FINISH;
        else if (burst_inc == BURST_MAX) state_d = S_RELEASE;
        else                             state_d = fill_q ? S_WRITE : S_READ;
      end
      S_RELEASE: begin
        burst_d = 8'd0;
        state_d = S_GRANT;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr_i)
      8'd0: rd_data = src_q[7:0];
      8'd1: rd_data = src_q[15:8];
      8'd2: rd_data = dst_q[7:0];
      8'd3: rd_data = dst_q[15:8];
      8'd4: rd_data = len_q[7:0];
      8'd5: rd_data = len_q[15:8];
      8'd6: rd_data = {5'b0, fill_q, irq_en_q, busy};
      8'd7: rd_data = {done_q, 6'b0, busy};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      src_q    <= 16'h0000;
      dst_q    <= 16'h0000;
      len_q    <= 16'h0000;
      burst_q  <= 8'd0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= 8'h00;
`ifdef DMA_FILL_EN
      fill_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      burst_q  <= burst_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      if (en_i && !we_i) dout_q <= rd_data;
`ifdef DMA_FILL_EN
      fill_q   <= fill_d;
`endif
    end
  end

  assign dout_o = dout_q;
  assign irq_o  = done_q & irq_en_q;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected bus writes/reads are queued when a transfer is
// programmed and compared against what the bus monitor captured.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, we = 1'b0;
  logic [7:0]  addr = 8'h00, din = 8'h00;
  logic [7:0]  dout_o, bus_dout_o;
  logic        rdy_o, bus_we_o, bus_own_o, irq_o;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_din = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$], obs_q[$];
  logic [15:0] exp_rd_q[$], obs_rd_q[$];
  int          gap_wr_q[$], gap_len_q[$];
  int          low_cnt, wr_cnt;

  dma_controller #(.BURST_LEN(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
    .dout_o(dout_o), .rdy_o(rdy_o), .bus_addr_o(bus_addr_o), .bus_dout_o(bus_dout_o),
    .bus_we_o(bus_we_o), .bus_din_i(bus_din), .bus_own_o(bus_own_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Memory image seen by the DMA, one-clock read latency.
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  always @(posedge clk) bus_din <= memf(bus_addr_o);

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); en = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1; en = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1; en = 1'b0; d = dout_o;
  endtask

  task automatic program_xfer(input logic [15:0] s, input logic [15:0] dst, input logic [15:0] len, input bit fill);
    cpu_write(8'd0, s[7:0]);   cpu_write(8'd1, s[15:8]);
    cpu_write(8'd2, dst[7:0]); cpu_write(8'd3, dst[15:8]);
    cpu_write(8'd4, len[7:0]); cpu_write(8'd5, len[15:8]);
    for (int i = 0; i < int'(len); i++) begin
      logic [15:0] sa, da;
      sa = fill ? s : s + 16'(i);
      da = dst + 16'(i);
      exp_q.push_back({da, fill ? s[7:0] : memf(sa)});
      if (!fill) exp_rd_q.push_back(sa);
    end
  endtask

  // Bounded observation window: captures bus traffic and RDY gaps.
  task automatic run_cycles(input int n);
    int hi_run; bit seen_low;
    low_cnt = 0; wr_cnt = 0; hi_run = 0; seen_low = 0;
    gap_wr_q.delete(); gap_len_q.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus_we_o) begin
        obs_q.push_back({bus_addr_o, bus_dout_o}); wr_cnt++;
        $display("bus write addr=%h data=%h", bus_addr_o, bus_dout_o);
      end else if (bus_own_o) obs_rd_q.push_back(bus_addr_o);
      if (!rdy_o) begin
        if (seen_low && hi_run > 0) begin gap_wr_q.push_back(wr_cnt); gap_len_q.push_back(hi_run); end
        hi_run = 0; seen_low = 1; low_cnt++;
      end else if (seen_low) hi_run++;
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); exp_rd_q.delete(); obs_rd_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (2) @(posedge clk); #1;
    n_checks++; if ({rdy_o, bus_own_o, bus_we_o, irq_o} !== 4'b1000) begin n_fail++;
      $display("FAIL reset_outputs got rdy/own/we/irq=%b want 1000", {rdy_o, bus_own_o, bus_we_o, irq_o}); end
    n_checks++; if (dout_o !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout_o); end
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      cpu_read(8'(a), d);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got %h want 00", a, d); end
    end
  endtask

  task automatic test_copy();
    logic [7:0] d; logic [7:0] want [8];
    clear_queues();
    program_xfer(16'h0200, 16'h8000, 16'd3, 1'b0);
    cpu_write(8'd6, 8'h01);
    run_cycles(10);
    while (exp_q.size() > 0) begin
      logic [23:0] e, o;
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL copy_write got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL copy_extra got %0d want 0", obs_q.size()); end
    n_checks++; if (low_cnt != 7) begin n_fail++; $display("FAIL copy_rdy_low got %0d want 7", low_cnt); end
    want = '{8'h03, 8'h02, 8'h03, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80};
    for (int a = 0; a < 8; a++) begin
      cpu_read(8'(a), d);
      n_checks++; if (d !== want[a]) begin n_fail++; $display("FAIL copy_reg%0d got %h want %h", a, d, want[a]); end
    end
  endtask

  task automatic test_burst();
    clear_queues();
    cpu_write(8'd7, 8'h00);
    program_xfer(16'h1000, 16'h9000, 16'd20, 1'b0);
    cpu_write(8'd6, 8'h01);
    run_cycles(50);
    while (exp_q.size() > 0) begin
      logic [23:0] e, o;
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL burst_write got %h want %h", o, e); end
    end
    n_checks++; if (wr_cnt != 20) begin n_fail++; $display("FAIL burst_count got %0d want 20", wr_cnt); end
    n_checks++; if (low_cnt != 43) begin n_fail++; $display("FAIL burst_rdy_low got %0d want 43", low_cnt); end
    n_checks++;
    if (gap_wr_q.size() != 2 || gap_wr_q[0] != 8 || gap_wr_q[1] != 16 || gap_len_q[0] != 1 || gap_len_q[1] != 1) begin
      n_fail++; $display("FAIL burst_gaps got %0d gaps (first at %0d) want 2 one-cycle gaps after 8,16",
                         gap_wr_q.size(), gap_wr_q.size() > 0 ? gap_wr_q[0] : -1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    clear_queues();
    program_xfer(16'hFFFE, 16'h7FFF, 16'd3, 1'b0);
    cpu_write(8'd6, 8'h01);
    run_cycles(10);
    while (exp_q.size() > 0) begin
      logic [23:0] e, o;
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL wrap_write got %h want %h", o, e); end
    end
    while (exp_rd_q.size() > 0) begin
      logic [15:0] e, o;
      e = exp_rd_q.pop_front(); o = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 16'hxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL wrap_read got %h want %h", o, e); end
    end
    cpu_read(8'd1, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_src_h got %h want 00", d); end
    cpu_read(8'd0, d);
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL wrap_src_l got %h want 01", d); end
  endtask

  task automatic test_len_zero_irq();
    logic [7:0] d;
    cpu_write(8'd7, 8'h00);
    cpu_write(8'd4, 8'h00); cpu_write(8'd5, 8'h00);
    cpu_write(8'd6, 8'h03);
    @(negedge clk);
    n_checks++; if ({irq_o, bus_we_o} !== 2'b00) begin n_fail++; $display("FAIL len0_early got irq/we=%b want 00", {irq_o, bus_we_o}); end
    @(negedge clk);
    n_checks++; if ({irq_o, bus_we_o} !== 2'b10) begin n_fail++; $display("FAIL len0_irq got irq/we=%b want 10", {irq_o, bus_we_o}); end
    cpu_read(8'd7, d);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL len0_status got %h want 80", d); end
    cpu_write(8'd7, 8'h00);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL len0_irq_clear got %b want 0", irq_o); end
    cpu_read(8'd7, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL len0_status_clear got %h want 00", d); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    clear_queues();
    program_xfer(16'h0300, 16'h4000, 16'd4, 1'b0);
    cpu_write(8'd6, 8'h01);
    cpu_write(8'd4, 8'h09);
    cpu_write(8'd0, 8'hFF);
    run_cycles(10);
    while (exp_q.size() > 0) begin
      logic [23:0] e, o;
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL busy_write got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL busy_extra got %0d want 0", obs_q.size()); end
    cpu_read(8'd4, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL busy_len got %h want 00", d); end
    cpu_write(8'h10, 8'h55);
    cpu_read(8'h10, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got %h want 00", d); end
  endtask

  task automatic test_status_set_wins();
    logic [7:0] d;
    cpu_write(8'd7, 8'h00);
    cpu_write(8'd4, 8'h01);
    cpu_write(8'd6, 8'h01);
    repeat (3) @(negedge clk);
    cpu_write(8'd7, 8'h00);
    cpu_read(8'd7, d);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL set_wins_status got %h want 80", d); end
  endtask

  task automatic test_fill_ctrl();
    logic [7:0] d;
    cpu_write(8'd6, 8'h06);
    cpu_read(8'd6, d);
`ifdef DMA_FILL_EN
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL ctrl_fill_bit got %h want 06", d); end
`else
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL ctrl_fill_bit got %h want 02", d); end
`endif
    cpu_write(8'd6, 8'h00);
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    clear_queues();
    program_xfer(16'h0500, 16'h6000, 16'd5, 1'b0);
    clear_queues();
    cpu_write(8'd6, 8'h03);
    repeat (5) @(negedge clk);
    n_checks++; if (bus_we_o !== 1'b1) begin n_fail++; $display("FAIL abort_in_write got we=%b want 1", bus_we_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({rdy_o, bus_own_o, bus_we_o} !== 3'b100) begin n_fail++;
      $display("FAIL abort_outputs got rdy/own/we=%b want 100", {rdy_o, bus_own_o, bus_we_o}); end
    @(negedge clk); rst_n = 1'b1;
    run_cycles(8);
    n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL abort_writes got %0d want 0", wr_cnt); end
    for (int a = 0; a < 8; a++) begin
      cpu_read(8'(a), d);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_reg%0d got %h want 00", a, d); end
    end
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    logic [7:0] d;
    clear_queues();
    program_xfer(16'h0020, 16'h8000, 16'd4, 1'b1);
    cpu_write(8'd6, 8'h05);
    run_cycles(10);
    while (exp_q.size() > 0) begin
      logic [23:0] e, o;
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL fill_write got %h want %h", o, e); end
    end
    n_checks++; if (low_cnt != 5) begin n_fail++; $display("FAIL fill_rdy_low got %0d want 5", low_cnt); end
    n_checks++; if (obs_rd_q.size() != 0) begin n_fail++; $display("FAIL fill_reads got %0d want 0", obs_rd_q.size()); end
    cpu_read(8'd0, d);
    n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL fill_src got %h want 20", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_burst();
    test_wrap();
    test_len_zero_irq();
    test_busy_ignore();
    test_status_set_wins();
    test_fill_ctrl();
    test_reset_abort();
`ifdef DMA_FILL_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, bytes moved per bus tenure before releasing the bus to the CPU for one cycle (legal 1..255).
REQ-002 SHALL have port clk_i  input  1  CPU clock; all logic on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports en_i input 1 register select ($94xx decode); we_i input 1 CPU write; addr_i input 8 register offset; din_i input 8 CPU write data.
REQ-005 SHALL have port dout_o  output  8  register read data, valid one clock after address (registered).
REQ-006 SHALL have port rdy_o  output  1  CPU RDY; low stalls CPU.
REQ-007 SHALL have ports bus_addr_o output 16, bus_dout_o output 8, bus_we_o output 1, bus_din_i input 8 (one-clock read latency), bus_own_o output 1 (high = DMA drives system bus mux).
REQ-008 SHALL have port irq_o  output  1  level interrupt, done AND irq-enable.

Function
REQ-009 SHALL decode offsets: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H, 6 CTRL, 7 STATUS; other offsets read 8'h00, writes ignored.
REQ-010 CTRL write: bit0=1 starts transfer, bit1 = irq enable (stored), bit2 = fill mode (see REQ-027); CTRL read: {5'b0, fill, irq_en, busy}.
REQ-011 STATUS read: {done, 6'b0, busy}; any STATUS write clears done.
REQ-012 Register writes to offsets 0-5 and start requests while busy SHALL be ignored; irq_en writes always accepted.
REQ-013 SHALL implement states IDLE, GRANT, READ, WRITE, RELEASE, FINISH.
REQ-014 IDLE: start with LEN!=0 -> GRANT; start with LEN=0 -> FINISH with zero bus cycles.
REQ-015 GRANT: rdy_o low for exactly one cycle, bus_own_o low, then -> READ.
REQ-016 READ: bus_own_o=1, bus_addr_o=SRC, bus_we_o=0; -> WRITE next cycle.
REQ-017 WRITE: bus_addr_o=DST, bus_dout_o=bus_din_i, bus_we_o=1; SRC+1, DST+1, LEN-1, burst count+1.
REQ-018 After WRITE: LEN reaches 0 -> FINISH; burst count = BURST_LEN -> RELEASE; else -> READ.
REQ-019 RELEASE: rdy_o=1, bus_own_o=0 for one cycle, burst count cleared, -> GRANT.
REQ-020 FINISH: set done, rdy_o=1, -> IDLE in one cycle.
REQ-021 rdy_o SHALL be low in GRANT, READ, WRITE; high otherwise. bus_we_o high only in WRITE.
REQ-022 SRC and DST SHALL wrap modulo 2^16 ($FFFF+1 = $0000); registers reflect live values during and after transfer.
REQ-023 Steady throughput: 2 cycles/byte, plus 2 overhead cycles (RELEASE+GRANT) per BURST_LEN bytes.
REQ-024 Simultaneous STATUS write and FINISH: done SHALL end set (set wins).
REQ-025 irq_o SHALL follow done AND irq_en combinationally from registers (no extra latency).

Reset
REQ-026 rst_n_i low at a rising edge: state IDLE, all registers 0, done=0, irq_en=0, rdy_o=1, bus_own_o=0, bus_we_o=0, dout_o=0, irq_o=0; aborts any transfer mid-operation with no further bus write.

Configuration
REQ-027 Macro DMA_FILL_EN defined: CTRL bit2 stored; in fill mode READ state is skipped, WRITE writes SRC_L to DST each cycle (1 cycle/byte), SRC unchanged, GRANT->WRITE and RELEASE->GRANT->WRITE.
REQ-028 Macro DMA_FILL_EN undefined: CTRL bit2 write ignored, reads 0, no fill logic synthesized.

Verification
REQ-029 SRC=$0200, DST=$8000, LEN=3, start -> writes $8000..$8002 with RAM data, rdy_o low 7 cycles, done=1, LEN=0, SRC=$0203.
REQ-030 LEN=20, BURST_LEN=8 -> rdy_o high exactly one cycle after bytes 8 and 16; 20 bus writes total.
REQ-031 SRC=$FFFE, DST=$7FFF, LEN=3 -> reads $FFFE,$FFFF,$0000; writes $7FFF,$8000,$8001.
REQ-032 LEN=0, irq_en=1, start -> no bus_we_o, done and irq_o high 2 cycles later; STATUS write clears both.
REQ-033 rst_n_i low during WRITE of byte 2 of 5 -> next cycle rdy_o=1, bus_own_o=0, all registers 0, no further writes.
REQ-034 DMA_FILL_EN defined, SRC_L=$20, DST=$8000, LEN=4, fill -> four writes of $20, rdy_o low 5 cycles.
